// File: rtl/seg_rom_disp_pkg.sv
// ============================================================================
// Module      : seg_rom_disp_pkg
// Description : Shared types, segment codes and helpers for the ROM display
//               stage (FSM states, 7-segment codes, double-dabble step).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_rom_disp_pkg;

  // Segment codes, {dp,g,f,e,d,c,b,a}, active-low
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         DP_BIT    = 7;

  // Conversion controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_e;

  // Map one BCD digit to its segment pattern; non-decimal codes show blank
  function automatic logic [7:0] seg_code(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the next doubling, so pre-add 3
  function automatic logic [3:0] dd_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_rom_disp_bin2bcd.sv
// ============================================================================
// Module      : bin2bcd_8
// Description : 8-bit binary to 3-digit BCD, iterative double-dabble.
//               start loads the operand; eight shift cycles follow and done
//               pulses for one cycle once bcd holds the result. bcd is held
//               until the next start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_8
  import seg_rom_disp_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  logic [7:0]  bin_q,  bin_d;
  logic [11:0] bcd_q,  bcd_d;
  logic [3:0]  cnt_q,  cnt_d;
  logic        done_q, done_d;
  logic [11:0] adj;

  // Load on start, otherwise run one correct-and-shift step per cycle
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    adj    = {dd_adj(bcd_q[11:8]), dd_adj(bcd_q[7:4]), dd_adj(bcd_q[3:0])};
    if (start) begin
      bin_d = bin;
      bcd_d = 12'd0;
      cnt_d = 4'd8;
    end else if (cnt_q != 4'd0) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q - 4'd1;
      done_d         = (cnt_q == 4'd1);
    end
  end

  // Converter registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_q  <= 8'd0;
      bcd_q  <= 12'd0;
      cnt_q  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: rtl/seg_rom_disp.sv
// ============================================================================
// Module      : seg_rom_disp
// Description : Shows ROM address (left 3 digits) and ROM data (right 3
//               digits) in decimal on a 6-digit scanned common-anode display.
//               A change on {addr,data} triggers a double-dabble conversion;
//               the scan runs independently of conversions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_rom_disp
  import seg_rom_disp_pkg::*;
#(
  parameter logic [15:0] CNT_SCAN_MAX = 16'd49_999,
  parameter bit          BLANK_LZ     = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic [5:0] sel,
  output logic [7:0] seg
);

  conv_state_e      state_q, state_d;
  logic [7:0]       cap_addr_q, cap_addr_d;
  logic [7:0]       cap_data_q, cap_data_d;
  logic [5:0][3:0]  dig_q, dig_d;    // index = scan position
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;

  logic             start;
  logic [11:0]      bcd_addr, bcd_data;
  logic             done_addr, done_data;

  // A new conversion only starts from IDLE, so changes while busy are
  // picked up on the first IDLE cycle and the last stable value wins
  assign start = (state_q == ST_IDLE) && ({addr, data} != {cap_addr_q, cap_data_q});

  bin2bcd_8 u_bcd_addr (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .bin       (addr),
    .bcd       (bcd_addr),
    .done      (done_addr)
  );

  bin2bcd_8 u_bcd_data (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .bin       (data),
    .bcd       (bcd_data),
    .done      (done_data)
  );

  // Conversion FSM: capture, wait for both converters, load digit registers
  always_comb begin
    state_d    = state_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    dig_d      = dig_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cap_addr_d = addr;
          cap_data_d = data;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (done_addr && done_data) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dig_d[0] = bcd_addr[11:8];
        dig_d[1] = bcd_addr[7:4];
        dig_d[2] = bcd_addr[3:0];
        dig_d[3] = bcd_data[11:8];
        dig_d[4] = bcd_data[7:4];
        dig_d[5] = bcd_data[3:0];
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan timing: dwell CNT_SCAN_MAX+1 clocks per digit, six digits
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    idx_d = idx_q;
    if (cnt_q == CNT_SCAN_MAX) begin
      cnt_d = 16'd0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : (idx_q + 3'd1);
    end
  end

  // Digit select and segment pattern, both derived from the same idx
  always_comb begin
    logic [2:0] base;
    logic [2:0] pos;
    logic       blank;
    base  = (idx_q < 3'd3) ? 3'd0 : 3'd3;
    pos   = idx_q - base;
    blank = 1'b0;
    if (BLANK_LZ) begin
      if (pos == 3'd0) begin
        blank = (dig_q[base] == 4'd0);
      end else if (pos == 3'd1) begin
        blank = (dig_q[base] == 4'd0) && (dig_q[base + 3'd1] == 4'd0);
      end
    end
    sel_d = 6'b100000 >> idx_q;
    seg_d = blank ? SEG_BLANK : seg_code(dig_q[idx_q]);
    // decimal point separates the address and data groups
    if (idx_q == 3'd2) begin
      seg_d[DP_BIT] = 1'b0;
    end
  end

  // State, capture, digit, scan and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cap_addr_q <= 8'd0;
      cap_data_q <= 8'd0;
      dig_q      <= '0;
      cnt_q      <= 16'd0;
      idx_q      <= 3'd0;
      sel_q      <= 6'b000000;
      seg_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_rom_disp.sv
// ============================================================================
// Module      : tb_seg_rom_disp
// Description : Bench for seg_rom_disp. Two instances (leading-zero blanking
//               on and off) share inputs. A reference model predicts each
//               clock's sel/seg and queues it; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_rom_disp;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] addr      = 8'd0;
  logic [7:0] data      = 8'd0;
  logic [5:0] sel_b, sel_n;
  logic [7:0] seg_b, seg_n;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  seg_rom_disp #(.CNT_SCAN_MAX(16'd9), .BLANK_LZ(1'b1)) dut_blank (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .addr      (addr),
    .data      (data),
    .sel       (sel_b),
    .seg       (seg_b)
  );

  seg_rom_disp #(.CNT_SCAN_MAX(16'd9), .BLANK_LZ(1'b0)) dut_zero (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .addr      (addr),
    .data      (data),
    .sel       (sel_n),
    .seg       (seg_n)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [5:0] sel;
    logic [7:0] seg_b;
    logic [7:0] seg_n;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int m_cap_a, m_cap_d;     // value being / last converted
  int m_disp_a, m_disp_d;   // value currently shown
  int m_busy;               // edges left until the shown value updates
  int m_edge;               // edges since reset release
  int m_idx;

  function automatic logic [7:0] exp_seg(input int idx, input bit blank_lz);
    int         val, pos, h, t, u, d;
    bit         bl;
    logic [7:0] code;
    val  = (idx < 3) ? m_disp_a : m_disp_d;
    pos  = idx % 3;
    h    = val / 100;
    t    = (val / 10) % 10;
    u    = val % 10;
    d    = (pos == 0) ? h : (pos == 1) ? t : u;
    bl   = blank_lz && (((pos == 0) && (h == 0)) || ((pos == 1) && (h == 0) && (t == 0)));
    code = bl ? 8'hFF : tbl[d];
    if (idx == 2) code[7] = 1'b0;
    return code;
  endfunction

  // Predict this edge's output from the pre-edge view, then advance model
  always @(posedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      m_cap_a = 0; m_cap_d = 0; m_disp_a = 0; m_disp_d = 0;
      m_busy  = 0; m_edge  = 0;
    end else begin
      m_idx   = (m_edge / 10) % 6;
      e.sel   = 6'b100000 >> m_idx;
      e.seg_b = exp_seg(m_idx, 1'b1);
      e.seg_n = exp_seg(m_idx, 1'b0);
      exp_q.push_back(e);
      m_edge++;
      if (m_busy == 0) begin
        if (int'(addr) != m_cap_a || int'(data) != m_cap_d) begin
          m_cap_a = int'(addr);
          m_cap_d = int'(data);
          m_busy  = 10;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_disp_a = m_cap_a;
          m_disp_d = m_cap_d;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      exp_q.delete();
      chk("rst_sel_blank", {2'b00, sel_b}, 8'h00);
      chk("rst_seg_blank", seg_b, 8'hFF);
      chk("rst_sel_zero",  {2'b00, sel_n}, 8'h00);
      chk("rst_seg_zero",  seg_n, 8'hFF);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sel_blank", {2'b00, sel_b}, {2'b00, e.sel});
      chk("seg_blank", seg_b, e.seg_b);
      chk("sel_zero",  {2'b00, sel_n}, {2'b00, e.sel});
      chk("seg_zero",  seg_n, e.seg_n);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  initial begin
    // reset held with toggling inputs
    repeat (6) begin
      tick(1);
      addr = 8'($urandom);
      data = 8'($urandom);
    end
    addr      = 8'd5;
    data      = 8'd255;
    sys_rst_n = 1'b1;
    tick(80);

    // change during conversion is ignored, then converted afterwards
    data = 8'd7;
    tick(3);
    data = 8'd200;
    tick(80);

    // all-zero address, data with leading zeros, address wrap
    addr = 8'd0;
    data = 8'd7;
    tick(80);
    addr = 8'd255;
    tick(40);
    addr = 8'd0;
    tick(40);

    // back-to-back changes
    data = 8'd1;
    tick(1);
    data = 8'd2;
    tick(12);
    data = 8'd30;
    tick(40);

    // randomized traffic, biased towards small values to exercise blanking
    repeat (150) begin
      case ($urandom_range(0, 3))
        0: ;
        1: begin
          addr = 8'($urandom_range(0, 15));
          data = 8'($urandom_range(0, 109));
        end
        default: begin
          addr = 8'($urandom);
          data = 8'($urandom);
        end
      endcase
      tick($urandom_range(1, 25));
    end

    // reset mid-conversion and mid-scan
    addr = 8'd123;
    data = 8'd45;
    tick(4);
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_sel", {2'b00, sel_b}, 8'h00);
    chk("async_rst_seg", seg_b, 8'hFF);
    tick(3);
    addr      = 8'd9;
    data      = 8'd0;
    sys_rst_n = 1'b1;
    tick(80);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
